// File: rtl/imem_loader.sv
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time instruction memory writer. Receives a counted byte
//             stream, assembles little-endian 32-bit words, writes them to
//             consecutive word addresses from 0 and releases the processor
//             reset only after the trailing checksum matches.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  output logic        we_o,
  output logic [31:0] wa_o,
  output logic [31:0] wd_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_reset_o
);

  // Word index must be able to count one past the last legal word.
  localparam int          IDX_W     = $clog2(MEM_WORDS + 1);
  localparam logic [15:0] MAX_WORDS = 16'(MEM_WORDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]       state_q;
  logic [2:0]       state_d;

  logic [15:0]      count_q;   // announced word count N
  logic [IDX_W-1:0] idx_q;     // index of the next word to be written
  logic [1:0]       lane_q;    // byte lane within the current word
  logic [7:0]       sum_q;     // running mod-256 sum of data bytes
  logic [23:0]      asm_q;     // lower three bytes of the word being built
  logic             we_q;
  logic [31:0]      wa_q;
  logic [31:0]      wd_q;

  logic             w_accept;
  logic [15:0]      w_count_full;
  logic             w_last_word;

  assign w_accept     = in_valid_i & in_ready_o;
  // Full count as it will be once the high byte currently on the bus lands.
  assign w_count_full = {in_data_i, count_q[7:0]};
  // The word completing now is the final one when index+1 reaches N.
  assign w_last_word  = ((16'(idx_q) + 16'd1) == count_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions only on accepted bytes or a start request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_accept) begin
          state_d = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (w_accept) begin
          if (w_count_full > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (w_count_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept && (lane_q == 2'd3) && w_last_word) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_accept) begin
          if (in_data_i == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded purely from the current state.
  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    cpu_reset_o = 1'b1;
    case (state_q)
      S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_DONE: begin
        done_o      = 1'b1;
        cpu_reset_o = 1'b0;
      end
      S_ERROR: begin
        err_o = 1'b1;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

  // Datapath: count capture, byte assembly, checksum and the write port.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 16'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      sum_q   <= 8'd0;
      asm_q   <= 24'd0;
      we_q    <= 1'b0;
      wa_q    <= 32'd0;
      wd_q    <= 32'd0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            idx_q  <= '0;
            lane_q <= 2'd0;
            sum_q  <= 8'd0;
          end
        end
        S_CNT_LO: begin
          if (w_accept) begin
            count_q[7:0] <= in_data_i;
          end
        end
        S_CNT_HI: begin
          if (w_accept) begin
            count_q[15:8] <= in_data_i;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            sum_q  <= sum_q + in_data_i;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: asm_q[7:0]   <= in_data_i;
              2'd1: asm_q[15:8]  <= in_data_i;
              2'd2: asm_q[23:16] <= in_data_i;
              default: begin
                // Fourth byte completes the word: issue the write.
                wd_q  <= {in_data_i, asm_q};
                wa_q  <= {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
                idx_q <= idx_q + 1'b1;
                we_q  <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          we_q <= 1'b0;
        end
      endcase
    end
  end

  assign we_o = we_q;
  assign wa_o = wa_q;
  assign wd_o = wd_q;

endmodule

`default_nettype wire
